beta_pc_unit: RTL and testbench
===============================

# beta_pc_unit

Program-counter unit for the Beta processor. It consumes the 3-bit `pcsel` produced by the instruction decoder and computes the next fetch address. It also latches external interrupt requests and presents the masked `irq` back to the decoder. It holds the PC register and the supervisor bit (PC[31]), and computes the PC+4 and branch-offset values that the datapath uses for LR/XP writeback and LDR addressing.

## Interface
- No parameters. Data width is fixed at 32 bits and the literal width at 16 bits.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pcsel`  in  3  next-PC select from the decoder: 0 = PC+4, 1 = branch, 2 = JMP, 3 = ILLOP, 4 = IRQ; 5–7 are treated as ILLOP.
- `jt`  in  32  jump target (register Ra value).
- `literal`  in  16  instruction bits [15:0].
- `stall`  in  1  when high, PC and interrupt-taken state hold.
- `irq_req`  in  1  external interrupt request; sampled every cycle.
- `pc`  out  32  current fetch address (registered).
- `pc_plus4`  out  32  {pc[31], pc[30:0]+4} (combinational from `pc`).
- `offset`  out  32  branch target {pc[31], pc_plus4[30:0] + (SXT(literal)<<2)} (combinational).
- `irq`  out  1  `irq_pending & ~pc[31]`, to the decoder.

## Operation
- State: `pc[31:0]`, with bits [1:0] always 0, and `irq_pending`.
- The next-PC mux, applied only when `stall`=0:
  - pcsel 0 → `pc_plus4`.
  - pcsel 1 → `offset`.
  - pcsel 2 → {pc[31] & jt[31], jt[30:2], 2'b00}. JMP can clear the supervisor bit but never set it.
  - pcsel 3, 5, 6, 7 → 32'h8000_0004 (ILLOP vector).
  - pcsel 4 → 32'h8000_0008 (IRQ vector).
- Arithmetic on the low 31 bits wraps modulo 2^31. Bit 31 is carried through unchanged for pcsel 0 and 1; a carry never reaches bit 31.
- `offset` uses the two's-complement sign extension of `literal` to 32 bits, shifted left 2, and the sum is truncated to 31 bits.
- Interrupt latch:
  - `irq_pending` sets on any cycle with `irq_req`=1.
  - It clears on a cycle with `stall`=0 and `pcsel`=4. In that cycle the clear wins over a simultaneous `irq_req`; devices hold their request level until serviced by software.
  - While pc[31]=1 (supervisor), `irq` is forced to 0 and the request stays pending. `irq` rises in the first cycle after PC returns to user mode.
- Stall:
  - `pc` holds.
  - `irq_pending` cannot clear, but it may still set.
  - Outputs continue to reflect the held `pc`.

## Timing
- Reset (synchronous, takes effect at the clock edge with `reset`=1, dominating all other inputs):
  - `pc` = 32'h8000_0000.
  - `irq_pending` = 0.
  - Therefore `irq` = 0, `pc_plus4` = 32'h8000_0004, and `offset` = 32'h8000_0004 + (SXT(literal)<<2) on bits [30:0].
- Latency:
  - `pcsel`/`jt`/`literal` → new `pc`: 1 cycle.
  - `pc` → `pc_plus4`/`offset`/`irq`: combinational, same cycle.
- `irq_req` → `irq`: visible the cycle after `irq_req` is sampled high, provided pc[31]=0.
- Reset asserted mid-operation: `pc` and `irq_pending` return to their reset values at the next edge. Pending interrupts are discarded.
- Back-to-back IRQ: after `pcsel`=4 is taken, the new PC is 0x8000_0008. Supervisor mode therefore masks `irq` even if `irq_req` stays high.

## Test plan
- Reset then 3 cycles with pcsel=0, stall=0 → `pc` = 8000_0000, 8000_0004, 8000_0008, 8000_000C.
- Set pc=0000_0100 via JMP (pc[31]=1, jt=0000_0100) → `pc`=0000_0100. Then pcsel=1 with literal=16'hFFFE → `pc`=0000_00FC. Then JMP with jt=8000_0200 from user mode → `pc`=0000_0200 (supervisor bit not set).
- Wrap: pc=7FFF_FFFC, pcsel=0 → `pc`=0000_0000. pc=FFFF_FFFC, pcsel=0 → `pc`=8000_0000.
- In user mode at pc=0000_0040, pulse irq_req for 1 cycle → `irq`=1 next cycle. Apply pcsel=4 → `pc`=8000_0008, `irq`=0, pending cleared. A pulse during supervisor mode keeps `irq`=0 until JMP to 0000_0044, then `irq`=1.
- pcsel=3, 5, 6, 7 each → `pc`=8000_0004. With stall=1 and pcsel=4 → `pc` unchanged and `irq_pending` stays 1.
- Reset asserted while irq_pending=1 and pc=0000_1000 → next cycle `pc`=8000_0000 and `irq_pending`=0.

Source files
------------

// File: rtl/beta_pc_unit.sv
// Beta program-counter unit: next-PC select, supervisor bit,
// PC+4 / branch-offset generation and the interrupt request latch.
module beta_pc_unit (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [2:0]  i_pcsel,
  input  logic [31:0] i_jt,
  input  logic [15:0] i_literal,
  input  logic        i_stall,
  input  logic        i_irq_req,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_offset,
  output logic        o_irq
);

  localparam logic [31:0] RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] IRQ_VEC   = 32'h8000_0008;

  localparam logic [2:0] SEL_INC = 3'd0;
  localparam logic [2:0] SEL_BR  = 3'd1;
  localparam logic [2:0] SEL_JMP = 3'd2;
  localparam logic [2:0] SEL_IRQ = 3'd4;

  logic [31:0] r_pc;
  logic        r_irq_pending;

  logic [31:0] w_sxt4;
  logic [30:0] w_inc;
  logic [30:0] w_br;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_offset;
  logic [31:0] w_jmp;
  logic [31:0] w_pc_next;
  logic        w_irq_take;

  // Low-31-bit arithmetic; bit 31 (supervisor) is carried through as-is
  assign w_sxt4     = {{14{i_literal[15]}}, i_literal, 2'b00};
  assign w_inc      = r_pc[30:0] + 31'd4;
  assign w_br       = w_inc + w_sxt4[30:0];
  assign w_pc_plus4 = {r_pc[31], w_inc};
  assign w_offset   = {r_pc[31], w_br};

  // JMP may drop the supervisor bit but can never raise it
  assign w_jmp = {r_pc[31] & i_jt[31], i_jt[30:2], 2'b00};

  assign w_irq_take = ~i_stall & (i_pcsel == SEL_IRQ);

  // Next-PC select; unused encodings fall into the ILLOP vector
  always_comb begin
    w_pc_next = ILLOP_VEC;
    case (i_pcsel)
      SEL_INC: w_pc_next = w_pc_plus4;
      SEL_BR:  w_pc_next = w_offset;
      SEL_JMP: w_pc_next = w_jmp;
      SEL_IRQ: w_pc_next = IRQ_VEC;
      default: w_pc_next = ILLOP_VEC;
    endcase
  end

  // PC register: holds on stall
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc <= RESET_VEC;
    end else if (!i_stall) begin
      r_pc <= w_pc_next;
    end
  end

  // Interrupt latch: taking the IRQ clears it even if the request persists
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_irq_pending <= 1'b0;
    end else if (w_irq_take) begin
      r_irq_pending <= 1'b0;
    end else if (i_irq_req) begin
      r_irq_pending <= 1'b1;
    end
  end

  assign o_pc       = r_pc;
  assign o_pc_plus4 = w_pc_plus4;
  assign o_offset   = w_offset;
  assign o_irq      = r_irq_pending & ~r_pc[31];

endmodule

// File: tb/tb_beta_pc_unit.sv
// Directed self-checking bench for beta_pc_unit.
// Inputs change 1 time unit after the rising edge.
module tb_beta_pc_unit;

  logic        clk;
  logic        reset;
  logic [2:0]  pcsel;
  logic [31:0] jt;
  logic [15:0] literal;
  logic        stall;
  logic        irq_req;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] offset;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  beta_pc_unit dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_pcsel   (pcsel),
    .i_jt      (jt),
    .i_literal (literal),
    .i_stall   (stall),
    .i_irq_req (irq_req),
    .o_pc      (pc),
    .o_pc_plus4(pc_plus4),
    .o_offset  (offset),
    .o_irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic jmp(input logic [31:0] tgt);
    pcsel = 3'd2;
    jt    = tgt;
    tick();
  endtask

  logic [2:0] illops [4];

  initial begin
    illops = '{3'd3, 3'd5, 3'd6, 3'd7};
    reset   = 1'b1;
    pcsel   = 3'd0;
    jt      = '0;
    literal = '0;
    stall   = 1'b0;
    irq_req = 1'b1;
    tick();
    // reset state, reset dominates irq_req
    check("rst_pc", pc, 32'h8000_0000);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_p4", pc_plus4, 32'h8000_0004);
    check("rst_off0", offset, 32'h8000_0004);
    literal = 16'h0001;
    #1;
    check("rst_off1", offset, 32'h8000_0008);
    irq_req = 1'b0;
    literal = 16'h0000;
    tick();
    check("rst_pc2", pc, 32'h8000_0000);
    reset = 1'b0;

    // sequential increment
    tick(); check("inc1", pc, 32'h8000_0004);
    tick(); check("inc2", pc, 32'h8000_0008);
    tick(); check("inc3", pc, 32'h8000_000C);

    // JMP to user, branch back, JMP cannot set supervisor
    jmp(32'h0000_0100);
    check("jmp_user", pc, 32'h0000_0100);
    check("p4_user", pc_plus4, 32'h0000_0104);
    literal = 16'hFFFE;
    #1;
    check("off_neg", offset, 32'h0000_00FC);
    pcsel = 3'd1;
    tick();
    check("br_neg", pc, 32'h0000_00FC);
    literal = 16'h0000;
    jmp(32'h8000_0200);
    check("jmp_nosv", pc, 32'h0000_0200);

    // wrap in user mode
    jmp(32'h7FFF_FFFC);
    check("pc_7ffc", pc, 32'h7FFF_FFFC);
    pcsel = 3'd0;
    tick();
    check("wrap_usr", pc, 32'h0000_0000);

    // wrap in supervisor mode
    reset = 1'b1; tick(); reset = 1'b0;
    jmp(32'hFFFF_FFFC);
    check("pc_fffc", pc, 32'hFFFF_FFFC);
    literal = 16'h0001;
    #1;
    check("off_wrap", offset, 32'h8000_0004);
    literal = 16'h0000;
    pcsel = 3'd0;
    tick();
    check("wrap_sv", pc, 32'h8000_0000);

    // interrupt in user mode
    jmp(32'h0000_0040);
    check("irq_idle", {31'd0, irq}, 32'd0);
    pcsel = 3'd0;
    irq_req = 1'b1;
    tick();
    irq_req = 1'b0;
    check("irq_pc44", pc, 32'h0000_0044);
    check("irq_up", {31'd0, irq}, 32'd1);
    pcsel = 3'd4;
    tick();
    check("irq_vec", pc, 32'h8000_0008);
    check("irq_mask", {31'd0, irq}, 32'd0);
    jmp(32'h0000_0048);
    check("irq_clr", {31'd0, irq}, 32'd0);

    // pulse in supervisor stays masked until user mode
    pcsel = 3'd4;
    tick();
    check("irq_vec2", pc, 32'h8000_0008);
    pcsel = 3'd0;
    irq_req = 1'b1;
    tick();
    irq_req = 1'b0;
    check("sv_mask1", {31'd0, irq}, 32'd0);
    tick();
    check("sv_pc", pc, 32'h8000_0010);
    check("sv_mask2", {31'd0, irq}, 32'd0);
    jmp(32'h0000_0044);
    check("sv_ret", pc, 32'h0000_0044);
    check("sv_irq", {31'd0, irq}, 32'd1);

    // clear wins over a simultaneous request
    pcsel = 3'd4;
    irq_req = 1'b1;
    tick();
    irq_req = 1'b0;
    jmp(32'h0000_0050);
    check("clr_wins", {31'd0, irq}, 32'd0);

    // ILLOP encodings
    foreach (illops[i]) begin
      pcsel = 3'd0;
      tick();
      pcsel = illops[i];
      tick();
      check($sformatf("illop%0d", illops[i]), pc, 32'h8000_0004);
    end

    // stall holds pc, pending may set but not clear
    jmp(32'h0000_0060);
    stall = 1'b1;
    pcsel = 3'd4;
    irq_req = 1'b1;
    tick();
    irq_req = 1'b0;
    check("stl_pc", pc, 32'h0000_0060);
    check("stl_set", {31'd0, irq}, 32'd1);
    tick();
    check("stl_pc2", pc, 32'h0000_0060);
    check("stl_p4", pc_plus4, 32'h0000_0064);
    check("stl_hold", {31'd0, irq}, 32'd1);
    stall = 1'b0;

    // reset mid-operation discards the pending request
    jmp(32'h0000_1000);
    check("pre_rst", pc, 32'h0000_1000);
    check("pre_irq", {31'd0, irq}, 32'd1);
    reset = 1'b1;
    pcsel = 3'd0;
    tick();
    reset = 1'b0;
    check("mid_rst", pc, 32'h8000_0000);
    check("mid_irq", {31'd0, irq}, 32'd0);
    jmp(32'h0000_2000);
    check("rst_drop", {31'd0, irq}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
